alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning the number of clk cycles alu_out/alu_ov are allowed to settle before capture (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port cmd_valid  input  1  command offered.
REQ-005 The block SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 The block SHALL have port cmd_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NEG, 6-7 illegal.
REQ-007 The block SHALL have ports cmd_a and cmd_b  input  64 each  operands.
REQ-008 The block SHALL have ports alu_a and alu_b  output  64 each  registered operands to the ALU.
REQ-009 The block SHALL have ports alu_b_inv, alu_sel0 and alu_sel1  output  1 each  registered ALU control.
REQ-010 The block SHALL have ports alu_out  input  64  and alu_ov  input  1  combinational ALU result and overflow.
REQ-011 The block SHALL have ports rsp_valid  output  1  and rsp_ready  input  1  response handshake.
REQ-012 The block SHALL have ports rsp_data  output  64,  rsp_ov  output  1  and rsp_err  output  1  response payload.
REQ-013 The block SHALL have port op_count  output  16  count of completed responses.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE, SETTLE_WAIT, CAPTURE and RESP.
REQ-015 IDLE: cmd_ready=1 only in IDLE; everywhere else cmd_ready=0.
REQ-016 On acceptance of a legal opcode, alu_* SHALL be registered in the same edge and the FSM SHALL go to DRIVE.
REQ-017 On acceptance of an illegal opcode, the FSM SHALL go to RESP; rsp_data=0, rsp_ov=0, rsp_err=1; alu_* SHALL be unchanged.
REQ-018 Opcode mapping {alu_b_inv,alu_sel1,alu_sel0} SHALL be: ADD 000, SUB 100, AND 001, OR 010, XOR 011, NEG 100 with alu_a=0 and alu_b=cmd_b.
REQ-019 All other legal ops SHALL drive alu_a=cmd_a and alu_b=cmd_b unmodified; all inversion/carry is done by the ALU.
REQ-020 The FSM SHALL go DRIVE -> SETTLE_WAIT; SETTLE_WAIT lasts SETTLE cycles (4-bit down-counter), then CAPTURE.
REQ-021 CAPTURE SHALL register rsp_data=alu_out, rsp_ov=alu_ov and rsp_err=0, then go to RESP.
REQ-022 For SETTLE=1, latency SHALL be: accept edge N; rsp_valid high from edge N+4.
REQ-023 alu_a, alu_b and the alu controls SHALL hold stable from DRIVE through RESP and retain their last values in IDLE.
REQ-024 RESP: rsp_valid=1; rsp_data, rsp_ov and rsp_err SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-025 When rsp_valid and rsp_ready are both high, the block SHALL go to IDLE on that edge; rsp_valid=0 next cycle; op_count increments by 1.
REQ-026 No back-to-back acceptance: a new command SHALL be accepted no earlier than the cycle after the response handshake.
REQ-027 op_count SHALL wrap from 16'hFFFF to 16'h0000 with no flag; illegal-op responses are counted.
REQ-028 cmd_* SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RESP.
REQ-029 If SETTLE is 0, the block SHALL treat it as 1.

Reset
REQ-030 With rst_n=0 at a rising clk edge, the block SHALL go to IDLE with cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_ov=0, rsp_err=0, alu_a=0, alu_b=0, alu_b_inv=0, alu_sel0=0, alu_sel1=0, op_count=0 and the settle counter at 0.
REQ-031 Reset asserted in any state, including mid-SETTLE_WAIT or RESP with a pending response, SHALL discard the operation without incrementing op_count.
REQ-032 Reset SHALL take priority over both handshakes in the same cycle.

Verification (with a behavioural ALU model on alu_*)
REQ-033 ADD: a=0x10, b=0x4, op 0, rsp_ready=1 -> rsp_data=0x14, rsp_ov=0, rsp_err=0, rsp_valid on edge N+4, op_count=1.
REQ-034 SUB/NEG: a=0x10, b=0x4, op 1 -> rsp_data=0xC and alu_b_inv=1; a=don't-care, b=0x0FF0, op 5 -> alu_a=0, rsp_data=0xFFFF_FFFF_FFFF_F010.
REQ-035 Logic ops: a=0xF0, b=0xFF0 with ops 2, 3 and 4 -> rsp_data=0xF0, 0xFF0 and 0xF00 respectively; sel bits match REQ-018.
REQ-036 Overflow and backpressure: a=0x7FFF_FFFF_FFFF_FFFF, b=1, op 0, rsp_ready=0 for 5 cycles -> rsp_ov=1, payload stable, cmd_ready=0 throughout; handshake -> IDLE.
REQ-037 Illegal op 7 -> rsp_err=1, rsp_data=0, rsp_valid one cycle after acceptance, alu_* unchanged, op_count increments.
REQ-038 Reset mid-op: assert rst_n=0 during SETTLE_WAIT -> next cycle all outputs equal REQ-030 values, op_count unchanged at 0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a combinational 64-bit ALU: registers operands/controls,
// waits SETTLE cycles for the result, captures it and hands it back over a valid/ready response.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_a,
  input  logic [63:0] cmd_b,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic        alu_b_inv,
  output logic        alu_sel0,
  output logic        alu_sel1,
  input  logic [63:0] alu_out,
  input  logic        alu_ov,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_ov,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE_WAIT, CAPTURE, RESP} state_t;
  typedef struct packed {
    logic b_inv;
    logic sel1;
    logic sel0;
  } alu_ctrl_t;

  // A zero settle time still needs one cycle for the operand registers to reach the ALU.
  localparam logic [3:0] SETTLE_CYC = (SETTLE == 0) ? 4'd1 : 4'(SETTLE);

  localparam logic [2:0] OP_NEG = 3'd5;

  state_t    state, nxt;
  alu_ctrl_t ctrl_q, op_ctrl;
  logic [3:0] settle_cnt;
  logic       legal;

  assign legal = (cmd_op <= OP_NEG);

  always_comb begin
    op_ctrl = '0;
    case (cmd_op)
      3'd1:    op_ctrl = '{b_inv: 1'b1, sel1: 1'b0, sel0: 1'b0};
      3'd2:    op_ctrl = '{b_inv: 1'b0, sel1: 1'b0, sel0: 1'b1};
      3'd3:    op_ctrl = '{b_inv: 1'b0, sel1: 1'b1, sel0: 1'b0};
      3'd4:    op_ctrl = '{b_inv: 1'b0, sel1: 1'b1, sel0: 1'b1};
      3'd5:    op_ctrl = '{b_inv: 1'b1, sel1: 1'b0, sel0: 1'b0};
      default: op_ctrl = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:        if (cmd_valid) nxt = legal ? DRIVE : RESP;
      DRIVE:       nxt = SETTLE_WAIT;
      SETTLE_WAIT: if (settle_cnt <= 4'd1) nxt = CAPTURE;
      CAPTURE:     nxt = RESP;
      RESP:        if (rsp_ready) nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      ctrl_q     <= '0;
      settle_cnt <= '0;
      rsp_data   <= '0;
      rsp_ov     <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          if (legal) begin
            alu_a  <= (cmd_op == OP_NEG) ? 64'd0 : cmd_a;
            alu_b  <= cmd_b;
            ctrl_q <= op_ctrl;
          end else begin
            rsp_data <= '0;
            rsp_ov   <= 1'b0;
            rsp_err  <= 1'b1;
          end
        end
        DRIVE:       settle_cnt <= SETTLE_CYC;
        SETTLE_WAIT: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        CAPTURE: begin
          rsp_data <= alu_out;
          rsp_ov   <= alu_ov;
          rsp_err  <= 1'b0;
        end
        RESP:        if (rsp_ready) op_count <= op_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign alu_b_inv = ctrl_q.b_inv;
  assign alu_sel1  = ctrl_q.sel1;
  assign alu_sel0  = ctrl_q.sel0;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU on the alu_* ports.
module tb_alu_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [63:0] cmd_a, cmd_b;
  logic [63:0] alu_a, alu_b, alu_out;
  logic        alu_b_inv, alu_sel0, alu_sel1, alu_ov;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_ov, rsp_err;
  logic [15:0] op_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_b_inv(alu_b_inv),
    .alu_sel0(alu_sel0), .alu_sel1(alu_sel1),
    .alu_out(alu_out), .alu_ov(alu_ov),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ov(rsp_ov), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  // Behavioural ALU: add (with optional b inversion + carry-in) or bitwise logic.
  logic [63:0] bb, sum;
  assign bb  = alu_b_inv ? ~alu_b : alu_b;
  assign sum = alu_a + bb + {63'd0, alu_b_inv};
  always_comb begin
    alu_out = sum;
    alu_ov  = 1'b0;
    case ({alu_sel1, alu_sel0})
      2'b00: begin alu_out = sum; alu_ov = (alu_a[63] == bb[63]) && (sum[63] != alu_a[63]); end
      2'b01: alu_out = alu_a & alu_b;
      2'b10: alu_out = alu_a | alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, " rsp_data"},  rsp_data, 64'd0);
    chk({tag, " rsp_ov/err"}, {62'd0, rsp_ov, rsp_err}, 64'd0);
    chk({tag, " alu_a"}, alu_a, 64'd0);
    chk({tag, " alu_b"}, alu_b, 64'd0);
    chk({tag, " alu_ctrl"}, {61'd0, alu_b_inv, alu_sel1, alu_sel0}, 64'd0);
    chk({tag, " op_count"}, 64'(op_count), 64'd0);
  endtask

  // Full legal operation with rsp_ready held high: accept at edge N, response seen from edge N+4.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_alu_a, input logic [2:0] exp_ctrl,
                        input logic [63:0] exp_data, input logic exp_ov, input logic [15:0] exp_cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b1;
    step();  // edge N: accepted
    cmd_valid = 1'b0;
    chk({tag, " cmd_ready busy"}, 64'(cmd_ready), 64'd0);
    chk({tag, " alu_a"}, alu_a, exp_alu_a);
    chk({tag, " alu_b"}, alu_b, b);
    chk({tag, " alu_ctrl"}, {61'd0, alu_b_inv, alu_sel1, alu_sel0}, {61'd0, exp_ctrl});
    step(); step();  // N+2
    chk({tag, " rsp_valid early"}, 64'(rsp_valid), 64'd0);
    step();  // N+3: response registered, visible at edge N+4
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, " rsp_data"}, rsp_data, exp_data);
    chk({tag, " rsp_ov/err"}, {62'd0, rsp_ov, rsp_err}, {62'd0, exp_ov, 1'b0});
    step();  // N+4: handshake
    chk({tag, " rsp_valid after hs"}, 64'(rsp_valid), 64'd0);
    chk({tag, " op_count"}, 64'(op_count), 64'(exp_cnt));
  endtask

  initial begin
    logic [63:0] hold_data;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    step(); step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    run_op("add", 3'd0, 64'h10, 64'h4, 64'h10, 3'b000, 64'h14, 1'b0, 16'd1);
    run_op("sub", 3'd1, 64'h10, 64'h4, 64'h10, 3'b100, 64'hC, 1'b0, 16'd2);
    run_op("neg", 3'd5, 64'h1234, 64'h0FF0, 64'h0, 3'b100, 64'hFFFF_FFFF_FFFF_F010, 1'b0, 16'd3);
    run_op("and", 3'd2, 64'hF0, 64'hFF0, 64'hF0, 3'b001, 64'hF0, 1'b0, 16'd4);
    run_op("or",  3'd3, 64'hF0, 64'hFF0, 64'hF0, 3'b010, 64'hFF0, 1'b0, 16'd5);
    run_op("xor", 3'd4, 64'hF0, 64'hFF0, 64'hF0, 3'b011, 64'hF00, 1'b0, 16'd6);

    // Overflow with backpressure; a second command offered meanwhile must be ignored.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 64'h7FFF_FFFF_FFFF_FFFF; cmd_b = 64'h1; rsp_ready = 1'b0;
    step();
    cmd_op = 3'd2; cmd_a = 64'hAAAA; cmd_b = 64'h5555;
    step(); step(); step();
    chk("ovf rsp_valid", 64'(rsp_valid), 64'd1);
    chk("ovf rsp_data", rsp_data, 64'h8000_0000_0000_0000);
    chk("ovf rsp_ov/err", {62'd0, rsp_ov, rsp_err}, 64'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp rsp_data", rsp_data, 64'h8000_0000_0000_0000);
      chk("bp rsp_ov", 64'(rsp_ov), 64'd1);
      chk("bp cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp alu_a", alu_a, 64'h7FFF_FFFF_FFFF_FFFF);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    step();
    chk("bp hs rsp_valid", 64'(rsp_valid), 64'd0);
    chk("bp hs cmd_ready", 64'(cmd_ready), 64'd1);
    chk("bp hs op_count", 64'(op_count), 64'd7);

    // Illegal opcode: straight to RESP with error, ALU registers untouched.
    hold_data = rsp_data;
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_a = 64'h1111; cmd_b = 64'h2222; rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("ill rsp_valid", 64'(rsp_valid), 64'd1);
    chk("ill rsp_err", 64'(rsp_err), 64'd1);
    chk("ill rsp_data", rsp_data, 64'd0);
    chk("ill rsp_data changed", 64'(rsp_data != hold_data), 64'd1);
    chk("ill alu_a", alu_a, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("ill alu_b", alu_b, 64'h1);
    step();
    chk("ill hs rsp_valid", 64'(rsp_valid), 64'd0);
    chk("ill op_count", 64'(op_count), 64'd8);

    // Reset mid SETTLE_WAIT, starting from a fresh counter.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 64'h10; cmd_b = 64'h4; rsp_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();  // now in SETTLE_WAIT
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_reset_vals("mid rst");
    step();

    // Reset wins over a response handshake in the same cycle.
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 64'hF0; cmd_b = 64'hFF0; rsp_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    chk("prio rsp_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_reset_vals("prio rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
